sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter AW, default 22, SDRAM word-address width.
REQ-002 Parameter TIMEOUT, default 255, maximum WAIT-state cycles before abort (8-bit counter).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 dl_wr  in  1  one-cycle download byte strobe.
REQ-006 dl_addr  in  AW+1  download byte address; bit 0 selects byte lane.
REQ-007 dl_data  in  8  download byte.
REQ-008 dl_busy  out  1  download holding register occupied.
REQ-009 dl_overrun  out  1  sticky flag: dl_wr arrived while holding register full.
REQ-010 cpuN_rd (N=0,1)  in  1  level read request; held until cpuN_valid.
REQ-011 cpuN_addr  in  AW  word address; stable while cpuN_rd high.
REQ-012 cpuN_q  out  16  read data.
REQ-013 cpuN_valid  out  1  one-cycle pulse: cpuN_q updated.
REQ-014 mem_req  out  1  toggle request to SDRAM port.
REQ-015 mem_ack  in  1  toggle acknowledge; transaction complete when mem_ack==mem_req.
REQ-016 mem_addr  out  AW, mem_we  out  1, mem_ds  out  2, mem_d  out  16: registered command fields.
REQ-017 mem_q  in  16  read data, valid when mem_ack==mem_req.
REQ-018 timeout_err  out  1  sticky flag: transaction aborted on timeout.

Function
REQ-019 FSM states: IDLE, WAIT; exactly one SDRAM transaction outstanding.
REQ-020 IDLE priority: pending download > CPU read; between CPUs, round-robin via last_grant bit (grant the CPU not last served when both request; otherwise the sole requester).
REQ-021 On grant: same edge registers mem_addr/mem_we/mem_ds/mem_d, toggles mem_req, clears timeout counter, enters WAIT.
REQ-022 Download grant: mem_addr=dl_addr[AW:1], mem_we=1, mem_ds={addr0,~addr0}, mem_d={byte,byte}; holding register freed at grant edge.
REQ-023 CPU grant: mem_we=0, mem_ds=2'b11, mem_addr=cpuN_addr.
REQ-024 WAIT: edge sampling mem_ack==mem_req returns to IDLE; on a read, same edge loads cpuN_q from mem_q, and cpuN_valid is high the following cycle only.
REQ-025 Minimum read latency: rd sampled edge 0, mem_req toggles edge 0, ack sampled edge K, valid high in cycle K+1; new grant possible at edge K+1.
REQ-026 cpuN_rd dropped mid-transaction: transaction completes, cpuN_q updated, valid still pulsed.
REQ-027 dl_wr with holding register empty: capture addr/data, dl_busy=1 next cycle; dl_wr and download grant on same edge: new byte captured, dl_busy stays 1.
REQ-028 dl_wr with register full and not freed that edge: byte dropped, dl_overrun set.
REQ-029 WAIT counter reaches TIMEOUT: timeout_err set, return to IDLE, mem_req set equal to mem_ack (resync), read requester gets cpuN_q=16'hFFFF with valid pulse.

Reset
REQ-030 reset_n low at an edge: state=IDLE, mem_req=mem_ack sampled value, mem_addr/mem_d=0, mem_we=0, mem_ds=0, cpuN_q=0, cpuN_valid=0, dl_busy=0, dl_overrun=0, timeout_err=0, last_grant=1 (CPU0 first).
REQ-031 Reset mid-WAIT abandons the transaction; no valid pulse issued.

Configuration
REQ-032 Macro ARB_HIT_CACHE_EN defined: per-CPU tag+valid holding last completed read address; in IDLE, cpuN_rd with cpuN_addr==tag and tag valid yields cpuN_valid next cycle with no mem_req toggle; any download grant or timeout invalidates both tags; reset clears them.
REQ-033 Macro undefined: no tag storage; every read issues an SDRAM transaction.

Verification
REQ-034 Single read: cpu0_rd, addr=0x01234, mem_q=0xBEEF, ack 3 cycles after toggle -> one mem_req toggle, cpu0_q=0xBEEF, one-cycle valid.
REQ-035 Both CPUs request continuously -> grants alternate CPU0,CPU1,CPU0,CPU1; no starvation over 16 transactions.
REQ-036 dl_wr at dl_addr=0x00003, data=0x5A while CPU read pending -> write issued first, mem_ds=2'b10, mem_d=0x5A5A, mem_we=1.
REQ-037 Two dl_wr on consecutive cycles during long WAIT -> second dropped, dl_overrun=1.
REQ-038 mem_ack never toggles -> after 255 WAIT cycles timeout_err=1, cpu_q=0xFFFF, FSM accepts next request.
REQ-039 ARB_HIT_CACHE_EN: repeat read of 0x00100 -> second read valid next cycle, no toggle; after a download write, same read re-issues SDRAM access.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Arbitrates a byte-wide download write port and two CPU read ports onto one toggle-handshake SDRAM port.
// Optional last-read hit cache per CPU is enabled with `define ARB_HIT_CACHE_EN.
module sdram_port_arbiter #(
   parameter int AW      = 22,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          dl_wr,
   input  logic [AW:0]   dl_addr,
   input  logic [7:0]    dl_data,
   output logic          dl_busy,
   output logic          dl_overrun,
   input  logic          cpu0_rd,
   input  logic [AW-1:0] cpu0_addr,
   output logic [15:0]   cpu0_q,
   output logic          cpu0_valid,
   input  logic          cpu1_rd,
   input  logic [AW-1:0] cpu1_addr,
   output logic [15:0]   cpu1_q,
   output logic          cpu1_valid,
   output logic          mem_req,
   input  logic          mem_ack,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [1:0]    mem_ds,
   output logic [15:0]   mem_d,
   input  logic [15:0]   mem_q,
   output logic          timeout_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

   state_t          state_q;
   logic            mem_req_q, mem_we_q;
   logic [AW-1:0]   mem_addr_q;
   logic [1:0]      mem_ds_q;
   logic [15:0]     mem_d_q;
   logic [7:0]      tmo_cnt_q, tmo_cnt_d;
   logic            op_rd_q, op_cpu1_q, last_grant_q;
   logic            dl_busy_q, dl_overrun_q, timeout_err_q;
   logic [AW:0]     dl_addr_q;
   logic [7:0]      dl_data_q;
   logic [15:0]     cpu0_data_q, cpu1_data_q;
   logic            cpu0_valid_q, cpu1_valid_q;

   logic            rd0_act, rd1_act, cpu_req, sel1, hit;
   logic [AW-1:0]   sel_addr;
   logic            grant_dl, grant_cpu, hit_serve, ack_seen, done, abort;

   // A requester whose valid is high this cycle is still holding rd; ignore it so it is not served twice.
   assign rd0_act   = cpu0_rd & ~cpu0_valid_q;
   assign rd1_act   = cpu1_rd & ~cpu1_valid_q;
   assign cpu_req   = rd0_act | rd1_act;
   assign sel1      = (rd0_act && rd1_act) ? ~last_grant_q : rd1_act;
   assign sel_addr  = sel1 ? cpu1_addr : cpu0_addr;

   assign grant_dl  = (state_q == S_IDLE) && dl_busy_q;
   assign grant_cpu = (state_q == S_IDLE) && !dl_busy_q && cpu_req && !hit;
   assign hit_serve = (state_q == S_IDLE) && !dl_busy_q && cpu_req && hit;
   assign ack_seen  = (mem_ack == mem_req_q);
   assign tmo_cnt_d = tmo_cnt_q + 8'd1;
   assign done      = (state_q == S_WAIT) && ack_seen;
   assign abort     = (state_q == S_WAIT) && !ack_seen && (tmo_cnt_d == TMO_LIMIT);

`ifdef ARB_HIT_CACHE_EN
   logic [AW-1:0] tag0_q, tag1_q;
   logic          tag0_v_q, tag1_v_q;

   assign hit = sel1 ? (tag1_v_q && (tag1_q == cpu1_addr))
                     : (tag0_v_q && (tag0_q == cpu0_addr));

   // Tags mirror the address behind cpuN_q; any write or aborted access may make them stale.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tag0_q   <= '0;
         tag1_q   <= '0;
         tag0_v_q <= 1'b0;
         tag1_v_q <= 1'b0;
      end else if (grant_dl || abort) begin
         tag0_v_q <= 1'b0;
         tag1_v_q <= 1'b0;
      end else if (done && op_rd_q) begin
         if (op_cpu1_q) begin
            tag1_q   <= mem_addr_q;
            tag1_v_q <= 1'b1;
         end else begin
            tag0_q   <= mem_addr_q;
            tag0_v_q <= 1'b1;
         end
      end
   end
`else
   assign hit = 1'b0;
`endif

   // NOTE: reset is synchronous, so it lives inside the clocked block and every state bit uses <=.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         mem_req_q     <= mem_ack;
         mem_addr_q    <= '0;
         mem_we_q      <= 1'b0;
         mem_ds_q      <= 2'b00;
         mem_d_q       <= '0;
         tmo_cnt_q     <= '0;
         op_rd_q       <= 1'b0;
         op_cpu1_q     <= 1'b0;
         last_grant_q  <= 1'b1;
         dl_busy_q     <= 1'b0;
         dl_overrun_q  <= 1'b0;
         dl_addr_q     <= '0;
         dl_data_q     <= '0;
         timeout_err_q <= 1'b0;
         cpu0_data_q   <= '0;
         cpu1_data_q   <= '0;
         cpu0_valid_q  <= 1'b0;
         cpu1_valid_q  <= 1'b0;
      end else begin
         cpu0_valid_q <= 1'b0;
         cpu1_valid_q <= 1'b0;

         // The holding register can be refilled on the same edge it is handed to the SDRAM port.
         if (dl_wr && (!dl_busy_q || grant_dl)) begin
            dl_addr_q <= dl_addr;
            dl_data_q <= dl_data;
            dl_busy_q <= 1'b1;
         end else begin
            if (dl_wr)    dl_overrun_q <= 1'b1;
            if (grant_dl) dl_busy_q    <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               if (grant_dl) begin
                  mem_addr_q <= dl_addr_q[AW:1];
                  mem_we_q   <= 1'b1;
                  mem_ds_q   <= {dl_addr_q[0], ~dl_addr_q[0]};
                  mem_d_q    <= {2{dl_data_q}};
                  mem_req_q  <= ~mem_req_q;
                  tmo_cnt_q  <= '0;
                  op_rd_q    <= 1'b0;
                  state_q    <= S_WAIT;
               end else if (grant_cpu) begin
                  mem_addr_q   <= sel_addr;
                  mem_we_q     <= 1'b0;
                  mem_ds_q     <= 2'b11;
                  mem_req_q    <= ~mem_req_q;
                  tmo_cnt_q    <= '0;
                  op_rd_q      <= 1'b1;
                  op_cpu1_q    <= sel1;
                  last_grant_q <= sel1;
                  state_q      <= S_WAIT;
               end else if (hit_serve) begin
                  if (sel1) cpu1_valid_q <= 1'b1;
                  else      cpu0_valid_q <= 1'b1;
                  last_grant_q <= sel1;
               end
            end
            S_WAIT: begin
               if (ack_seen) begin
                  state_q <= S_IDLE;
                  if (op_rd_q) begin
                     if (op_cpu1_q) begin
                        cpu1_data_q  <= mem_q;
                        cpu1_valid_q <= 1'b1;
                     end else begin
                        cpu0_data_q  <= mem_q;
                        cpu0_valid_q <= 1'b1;
                     end
                  end
               end else if (abort) begin
                  timeout_err_q <= 1'b1;
                  mem_req_q     <= mem_ack;
                  state_q       <= S_IDLE;
                  if (op_rd_q) begin
                     if (op_cpu1_q) begin
                        cpu1_data_q  <= 16'hFFFF;
                        cpu1_valid_q <= 1'b1;
                     end else begin
                        cpu0_data_q  <= 16'hFFFF;
                        cpu0_valid_q <= 1'b1;
                     end
                  end
               end else begin
                  tmo_cnt_q <= tmo_cnt_d;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dl_busy     = dl_busy_q;
   assign dl_overrun  = dl_overrun_q;
   assign cpu0_q      = cpu0_data_q;
   assign cpu0_valid  = cpu0_valid_q;
   assign cpu1_q      = cpu1_data_q;
   assign cpu1_valid  = cpu1_valid_q;
   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign mem_we      = mem_we_q;
   assign mem_ds      = mem_ds_q;
   assign mem_d       = mem_d_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter with a toggle-handshake SDRAM responder model.
// Cache-hit checks compile in only when ARB_HIT_CACHE_EN is defined.
module tb_sdram_port_arbiter;

   localparam int AW = 22;

   typedef struct {
      logic [AW-1:0] addr;
      logic          we;
      logic [1:0]    ds;
      logic [15:0]   d;
   } txn_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          dl_wr = 1'b0;
   logic [AW:0]   dl_addr = '0;
   logic [7:0]    dl_data = '0;
   logic          dl_busy, dl_overrun;
   logic          cpu0_rd = 1'b0, cpu1_rd = 1'b0;
   logic [AW-1:0] cpu0_addr = '0, cpu1_addr = '0;
   logic [15:0]   cpu0_q, cpu1_q;
   logic          cpu0_valid, cpu1_valid;
   logic          mem_req;
   logic          mem_ack = 1'b0;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [1:0]    mem_ds;
   logic [15:0]   mem_d;
   logic [15:0]   mem_q = '0;
   logic          timeout_err;

   int   checks = 0;
   int   failures = 0;
   txn_t txq[$];
   int   toggles = 0;
   bit   ack_en = 1'b1;
   bit   ack_init = 1'b0;
   int   ack_delay = 3;
   int   resp_cnt = 0;
   bit   resp_busy = 1'b0;
   bit   auto_drop = 1'b1;
   bit   seen0, seen1;
   int   v0 = 0, v1 = 0;
   logic [15:0] q0, q1;

   always #5 clk = ~clk;

   sdram_port_arbiter #(.AW(AW), .TIMEOUT(255)) dut (
      .clk(clk), .reset_n(reset_n),
      .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
      .dl_busy(dl_busy), .dl_overrun(dl_overrun),
      .cpu0_rd(cpu0_rd), .cpu0_addr(cpu0_addr), .cpu0_q(cpu0_q), .cpu0_valid(cpu0_valid),
      .cpu1_rd(cpu1_rd), .cpu1_addr(cpu1_addr), .cpu1_q(cpu1_q), .cpu1_valid(cpu1_valid),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_ds(mem_ds), .mem_d(mem_d), .mem_q(mem_q), .timeout_err(timeout_err)
   );

   function automatic logic [15:0] mem_fn(input logic [AW-1:0] a);
      if (a == 22'h01234) return 16'hBEEF;
      return a[15:0] ^ 16'hC3C3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // SDRAM responder: logs each new request, acknowledges ack_delay negedges after seeing the toggle.
   initial begin
      txn_t t;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            mem_ack   = ack_init;
            resp_busy = 1'b0;
         end else if (mem_req !== mem_ack) begin
            if (!resp_busy) begin
               resp_busy = 1'b1;
               resp_cnt  = 0;
               t.addr = mem_addr; t.we = mem_we; t.ds = mem_ds; t.d = mem_d;
               txq.push_back(t);
               toggles++;
            end
            resp_cnt++;
            if (ack_en && resp_cnt >= ack_delay) begin
               mem_q     = mem_fn(mem_addr);
               mem_ack   = mem_req;
               resp_busy = 1'b0;
            end
         end else begin
            resp_busy = 1'b0;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      seen0 = cpu0_valid;
      seen1 = cpu1_valid;
      if (seen0) begin q0 = cpu0_q; v0++; if (auto_drop) cpu0_rd = 1'b0; end
      if (seen1) begin q1 = cpu1_q; v1++; if (auto_drop) cpu1_rd = 1'b0; end
   endtask

   task automatic apply_reset(input bit ack_lvl);
      ack_init = ack_lvl;
      cpu0_rd  = 1'b0;
      cpu1_rd  = 1'b0;
      dl_wr    = 1'b0;
      reset_n  = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic read_one(input bit which, input logic [AW-1:0] addr,
                           output logic [15:0] data, output int lat);
      bit got = 1'b0;
      if (which) begin cpu1_addr = addr; cpu1_rd = 1'b1; end
      else       begin cpu0_addr = addr; cpu0_rd = 1'b1; end
      lat = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         step();
         lat++;
         got = which ? seen1 : seen0;
      end
      check("read_completes", {31'd0, got}, 32'd1);
      data = which ? q1 : q0;
      step();
      check("valid_one_cycle", {31'd0, (which ? cpu1_valid : cpu0_valid)}, 32'd0);
   endtask

   task automatic wait_v0(input int base);
      for (int i = 0; i < 400 && v0 == base; i++) step();
      check("cpu0_done_in_bound", {31'd0, (v0 != base)}, 32'd1);
   endtask

   initial begin
      logic [15:0] data;
      int lat, t0, vb;
      bit got;

      // Reset values
      apply_reset(1'b0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_ds", mem_ds, 0);
      check("rst_mem_d", mem_d, 0);
      check("rst_cpu_q", {cpu0_q, cpu1_q}, 0);
      check("rst_valid", {cpu0_valid, cpu1_valid}, 0);
      check("rst_dl_flags", {dl_busy, dl_overrun, timeout_err}, 0);
      check("rst_mem_req0", mem_req, 0);
      apply_reset(1'b1);
      check("rst_mem_req1", mem_req, 1);

      // Single read, ack 3 cycles after toggle
      txq.delete(); t0 = toggles;
      read_one(1'b0, 22'h01234, data, lat);
      check("rd0_data", data, 16'hBEEF);
      check("rd0_latency", lat, 4);
      check("rd0_toggles", toggles - t0, 1);
      check("rd0_txn", {txq[0].addr, txq[0].we, txq[0].ds}, {22'h01234, 1'b0, 2'b11});
      read_one(1'b1, 22'h00100, data, lat);
      check("rd1_data", data, 16'hC2C3);

      // Round-robin with both CPUs requesting continuously
      apply_reset(1'b1);
      ack_delay = 1; auto_drop = 1'b0; txq.delete();
      cpu0_addr = 22'h00010; cpu1_addr = 22'h00020;
      cpu0_rd = 1'b1; cpu1_rd = 1'b1;
      for (int i = 0; i < 300 && txq.size() < 16; i++) step();
      check("rr_16_txns", {31'd0, (txq.size() >= 16)}, 32'd1);
      for (int i = 0; i < 16 && i < txq.size(); i++)
         check($sformatf("rr_grant%0d", i), txq[i].addr, (i % 2) ? 22'h00020 : 22'h00010);
      cpu0_rd = 1'b0; cpu1_rd = 1'b0; auto_drop = 1'b1;
      repeat (10) step();

      // Pending download beats a pending CPU read
      ack_delay = 6; txq.delete(); vb = v0;
      cpu1_addr = 22'h00200; cpu1_rd = 1'b1;
      step();
      dl_addr = 23'h00003; dl_data = 8'h5A; dl_wr = 1'b1;
      cpu0_addr = 22'h00300; cpu0_rd = 1'b1;
      step();
      dl_wr = 1'b0;
      step();
      check("dl_busy_held", dl_busy, 1);
      wait_v0(vb);
      check("prio_q1", q1, 16'hC1C3);
      check("prio_q0", q0, 16'hC0C3);
      check("prio_ntxn", txq.size(), 3);
      if (txq.size() >= 3) begin
         check("prio_order_rd1", txq[0].addr, 22'h00200);
         check("prio_wr", {txq[1].addr, txq[1].we, txq[1].ds, txq[1].d},
               {22'h00001, 1'b1, 2'b10, 16'h5A5A});
         check("prio_order_rd0", txq[2].addr, 22'h00300);
      end
      check("dl_busy_freed", dl_busy, 0);

      // Refill of holding register on the grant edge
      ack_delay = 2; txq.delete();
      dl_addr = 23'h00020; dl_data = 8'h33; dl_wr = 1'b1;
      step();
      dl_addr = 23'h00041; dl_data = 8'h44;
      step();
      dl_wr = 1'b0;
      check("refill_busy", dl_busy, 1);
      check("refill_no_overrun", dl_overrun, 0);
      repeat (20) step();
      check("refill_ntxn", txq.size(), 2);
      if (txq.size() >= 2) begin
         check("refill_wrA", {txq[0].addr, txq[0].ds, txq[0].d}, {22'h00010, 2'b01, 16'h3333});
         check("refill_wrB", {txq[1].addr, txq[1].ds, txq[1].d}, {22'h00020, 2'b10, 16'h4444});
      end

      // Back-to-back download bytes during a long WAIT: second one dropped
      ack_delay = 20; txq.delete(); vb = v0;
      cpu0_addr = 22'h00400; cpu0_rd = 1'b1;
      step();
      dl_addr = 23'h00010; dl_data = 8'h11; dl_wr = 1'b1;
      step();
      dl_addr = 23'h00012; dl_data = 8'h22;
      step();
      dl_wr = 1'b0;
      check("overrun_set", dl_overrun, 1);
      wait_v0(vb);
      check("overrun_rd_data", q0, 16'hC7C3);
      ack_delay = 2;
      repeat (20) step();
      check("overrun_ntxn", txq.size(), 2);
      if (txq.size() >= 2)
         check("overrun_wr", {txq[1].addr, txq[1].we, txq[1].ds, txq[1].d},
               {22'h00008, 1'b1, 2'b01, 16'h1111});
      check("overrun_sticky", dl_overrun, 1);

      // Timeout: ack never arrives
      apply_reset(1'b1);
      check("overrun_cleared", dl_overrun, 0);
      ack_en = 1'b0; ack_delay = 3;
      cpu0_addr = 22'h00500; cpu0_rd = 1'b1;
      lat = 0; got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         step();
         lat++;
         if (lat == 255) check("tmo_not_early", timeout_err, 0);
         got = seen0;
      end
      check("tmo_valid", {31'd0, got}, 32'd1);
      check("tmo_latency", lat, 256);
      check("tmo_q", q0, 16'hFFFF);
      check("tmo_err", timeout_err, 1);
      check("tmo_resync", {31'd0, mem_req}, {31'd0, mem_ack});
      ack_en = 1'b1;
      step();
      read_one(1'b1, 22'h00600, data, lat);
      check("post_tmo_data", data, 16'hC5C3);
      check("post_tmo_latency", lat, 4);
      check("tmo_err_sticky", timeout_err, 1);

      // Reset while waiting abandons the transaction silently
      ack_delay = 10;
      cpu0_addr = 22'h00700; cpu0_rd = 1'b1;
      repeat (3) step();
      vb = v0;
      apply_reset(1'b1);
      repeat (15) step();
      check("rstwait_no_valid", v0 - vb, 0);
      check("rstwait_q", cpu0_q, 0);
      check("rstwait_resync", {31'd0, mem_req}, {31'd0, mem_ack});
      check("rstwait_tmo_clr", timeout_err, 0);

`ifdef ARB_HIT_CACHE_EN
      // Repeat read hits the tag; a download write invalidates it
      ack_delay = 3; t0 = toggles;
      read_one(1'b0, 22'h00100, data, lat);
      check("hit_miss_toggles", toggles - t0, 1);
      read_one(1'b0, 22'h00100, data, lat);
      check("hit_data", data, 16'hC2C3);
      check("hit_latency", lat, 1);
      check("hit_no_toggle", toggles - t0, 1);
      dl_addr = 23'h00000; dl_data = 8'h00; dl_wr = 1'b1;
      step();
      dl_wr = 1'b0;
      repeat (10) step();
      read_one(1'b0, 22'h00100, data, lat);
      check("hit_inval_toggles", toggles - t0, 3);
      check("hit_inval_latency", lat, 4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
